// File: rtl/multicycle_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : IF/ID/EXE/MEM/WB control FSM for the multi-cycle MIPS-subset
//            CPU. It drives the PC-source select and the PC/IR/register-file/
//            memory/ALU strobes.
// Options  : define CTRL_BLTZ_EN to add the bltz instruction and 'sign' input
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef CTRL_BLTZ_EN
  input  logic       sign,
`endif
  output logic [1:0] PCSrc,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       MemRd,
  output logic       MemWr,
  output logic       DBDataSrc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  state_t cur_state;

  // Instruction class decode from the IR fields
  logic is_rtype, is_ralu, is_jr, is_addiu, is_ori, is_lw, is_sw;
  logic is_beq, is_bne, is_bltz, is_j, is_jal, is_halt;
  logic is_br, is_ls, is_alu, br_taken;

  assign is_rtype = (op == OP_RTYPE);
  assign is_ralu  = is_rtype && ((funct == F_ADD) || (funct == F_SUB) ||
                                 (funct == F_AND) || (funct == F_OR)  ||
                                 (funct == F_SLT));
  assign is_jr    = is_rtype && (funct == F_JR);
  assign is_addiu = (op == OP_ADDIU);
  assign is_ori   = (op == OP_ORI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_halt  = (op == OP_HALT);

`ifdef CTRL_BLTZ_EN
  assign is_bltz  = (op == 6'b000001);
  assign br_taken = (is_beq & zero) | (is_bne & ~zero) | (is_bltz & sign);
`else
  assign is_bltz  = 1'b0;
  assign br_taken = (is_beq & zero) | (is_bne & ~zero);
`endif

  assign is_br  = is_beq | is_bne | is_bltz;
  assign is_ls  = is_lw | is_sw;
  assign is_alu = is_ralu | is_addiu | is_ori;

  // State register with next-state sequencing; reset returns to fetch
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cur_state <= S_IF;
    end else begin
      case (cur_state)
        S_IF:     cur_state <= S_ID;
        S_ID: begin
          if (is_br)       cur_state <= S_EXE_BR;
          else if (is_ls)  cur_state <= S_EXE_LS;
          else if (is_alu) cur_state <= S_EXE_AL;
          else             cur_state <= S_IF;   // jumps, halt, undefined
        end
        S_EXE_AL: cur_state <= S_WB_AL;
        S_WB_AL:  cur_state <= S_IF;
        S_EXE_BR: cur_state <= S_IF;
        S_EXE_LS: cur_state <= S_MEM;
        S_MEM:    cur_state <= is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  cur_state <= S_IF;
        default:  cur_state <= S_IF;
      endcase
    end
  end

  // Output decode; reset forces every output low so no stray write escapes
  always_comb begin
    PCSrc     = 2'b00;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b1;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    DBDataSrc = 1'b0;
    state     = cur_state;

    case (cur_state)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (is_jal) begin
          PCWre     = 1'b1;
          PCSrc     = 2'b11;
          RegWre    = 1'b1;
          RegDst    = 2'b10;
          WrRegDSrc = 1'b0;
        end else if (is_j) begin
          PCWre = 1'b1;
          PCSrc = 2'b11;
        end else if (is_jr) begin
          PCWre = 1'b1;
          PCSrc = 2'b10;
        end else if (!is_halt && !is_br && !is_ls && !is_alu) begin
          PCWre = 1'b1;                       // undefined opcode: plain nop
        end
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = br_taken ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        MemRd = is_lw;
        MemWr = is_sw;
        PCWre = is_sw;
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
        RegDst = is_rtype ? 2'b01 : 2'b00;
      end
      default: ;
    endcase

    // ALU controls are held through the EXE state and the one after it
    if ((cur_state == S_EXE_AL) || (cur_state == S_WB_AL) ||
        (cur_state == S_EXE_LS) || (cur_state == S_MEM) ||
        (cur_state == S_EXE_BR)) begin
      if (is_rtype) begin
        case (funct)
          F_SUB:   ALUOp = 3'b001;
          F_AND:   ALUOp = 3'b010;
          F_OR:    ALUOp = 3'b011;
          F_SLT:   ALUOp = 3'b100;
          default: ALUOp = 3'b000;
        endcase
      end else if (is_addiu || is_ls) begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
      end else if (is_ori) begin
        ALUOp   = 3'b011;
        ALUSrcB = 1'b1;
      end else if (is_br) begin
        ALUOp = 3'b001;
      end
    end

    if (!RST_n) begin
      PCSrc     = 2'b00;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = 3'b000;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      DBDataSrc = 1'b0;
      state     = 3'b000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Directed self-checking bench for multicycle_control_unit. Each
//            cycle the full output vector is compared with a hand-built one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [5:0] op, funct;
  logic       zero;
`ifdef CTRL_BLTZ_EN
  logic       sign;
`endif
  logic [1:0] PCSrc, RegDst;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel;
  logic [2:0] ALUOp, state;
  logic       MemRd, MemWr, DBDataSrc;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_unit dut (
    .CLK(CLK), .RST_n(RST_n), .op(op), .funct(funct), .zero(zero),
`ifdef CTRL_BLTZ_EN
    .sign(sign),
`endif
    .PCSrc(PCSrc), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .MemRd(MemRd), .MemWr(MemWr),
    .DBDataSrc(DBDataSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  // Observed vector: state, PCSrc, PCWre, IRWre, RegWre, RegDst, WrRegDSrc,
  // ALUSrcB, ExtSel, ALUOp, MemRd, MemWr, DBDataSrc
  logic [18:0] obs;
  assign obs = {state, PCSrc, PCWre, IRWre, RegWre, RegDst, WrRegDSrc,
                ALUSrcB, ExtSel, ALUOp, MemRd, MemWr, DBDataSrc};

  function automatic logic [18:0] v(
    input logic [2:0] st, input logic [1:0] pcsrc, input logic pcwre,
    input logic irwre, input logic regwre, input logic [1:0] regdst,
    input logic wrsrc, input logic srcb, input logic ext,
    input logic [2:0] aluop, input logic memrd, input logic memwr,
    input logic dbsrc);
    return {st, pcsrc, pcwre, irwre, regwre, regdst, wrsrc, srcb, ext,
            aluop, memrd, memwr, dbsrc};
  endfunction

  task automatic check(input string tag, input logic [18:0] got,
                       input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [18:0] exp);
    @(negedge CLK);
    check(tag, obs, exp);
  endtask

  task automatic load(input logic [5:0] o, input logic [5:0] f,
                      input logic z);
    @(posedge CLK);
    #1;
    op = o; funct = f; zero = z;
  endtask

  logic [18:0] V_RST, V_IF, V_ID;
  logic [18:0] V_ADD_EX, V_ADD_WB;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    V_RST    = '0;
    V_IF     = v(3'd0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0);
    V_ID     = v(3'd1, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0);
    V_ADD_EX = v(3'd6, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0);
    V_ADD_WB = v(3'd7, 2'b00, 1, 0, 1, 2'b01, 1, 0, 0, 3'b000, 0, 0, 0);

    RST_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
`ifdef CTRL_BLTZ_EN
    sign = 1'b0;
`endif
    #3 check("reset_hold", obs, V_RST);
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1; op = 6'b000000; funct = 6'b100000;

    // add interrupted by reset during EXE_AL
    cyc("add0_if", V_IF);
    cyc("add0_id", V_ID);
    cyc("add0_exe", V_ADD_EX);
    #2 RST_n = 1'b0;
    #1 check("rst_mid_exe", obs, V_RST);
    @(posedge CLK);
    #1 check("rst_held_edge", obs, V_RST);
    RST_n = 1'b1;

    // add: full 4-cycle path
    cyc("add_if_release", V_IF);
    cyc("add_id", V_ID);
    cyc("add_exe", V_ADD_EX);
    cyc("add_wb", V_ADD_WB);

    // slt: funct-driven ALUOp
    load(6'b000000, 6'b101010, 0);
    cyc("slt_if", V_IF);
    cyc("slt_id", V_ID);
    cyc("slt_exe", v(3'd6, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 3'b100, 0, 0, 0));
    cyc("slt_wb",  v(3'd7, 2'b00, 1, 0, 1, 2'b01, 1, 0, 0, 3'b100, 0, 0, 0));

    // ori: zero-extended immediate, rt destination
    load(6'b001101, 6'b000000, 0);
    cyc("ori_if", V_IF);
    cyc("ori_id", V_ID);
    cyc("ori_exe", v(3'd6, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 3'b011, 0, 0, 0));
    cyc("ori_wb",  v(3'd7, 2'b00, 1, 0, 1, 2'b00, 1, 1, 0, 3'b011, 0, 0, 0));

    // addiu: sign-extended immediate
    load(6'b001001, 6'b111111, 0);
    cyc("addiu_if", V_IF);
    cyc("addiu_id", V_ID);
    cyc("addiu_wb_pre", v(3'd6, 2'b00, 0, 0, 0, 2'b00, 1, 1, 1, 3'b000, 0, 0, 0));
    cyc("addiu_wb", v(3'd7, 2'b00, 1, 0, 1, 2'b00, 1, 1, 1, 3'b000, 0, 0, 0));

    // beq taken / not taken, bne taken
    load(6'b000100, 6'b000000, 1);
    cyc("beq1_if", V_IF);
    cyc("beq1_id", V_ID);
    cyc("beq1_br", v(3'd5, 2'b01, 1, 0, 0, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0));
    load(6'b000100, 6'b000000, 0);
    cyc("beq0_if", V_IF);
    cyc("beq0_id", V_ID);
    cyc("beq0_br", v(3'd5, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0));
    load(6'b000101, 6'b000000, 0);
    cyc("bne0_if", V_IF);
    cyc("bne0_id", V_ID);
    cyc("bne0_br", v(3'd5, 2'b01, 1, 0, 0, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0));

    // lw: 5 cycles
    load(6'b100011, 6'b000000, 0);
    cyc("lw_if", V_IF);
    cyc("lw_id", V_ID);
    cyc("lw_exe", v(3'd2, 2'b00, 0, 0, 0, 2'b00, 1, 1, 1, 3'b000, 0, 0, 0));
    cyc("lw_mem", v(3'd3, 2'b00, 0, 0, 0, 2'b00, 1, 1, 1, 3'b000, 1, 0, 0));
    cyc("lw_wb",  v(3'd4, 2'b00, 1, 0, 1, 2'b00, 1, 0, 0, 3'b000, 0, 0, 1));

    // sw: 4 cycles, single MemWr
    load(6'b101011, 6'b000000, 0);
    cyc("sw_if", V_IF);
    cyc("sw_id", V_ID);
    cyc("sw_exe", v(3'd2, 2'b00, 0, 0, 0, 2'b00, 1, 1, 1, 3'b000, 0, 0, 0));
    cyc("sw_mem", v(3'd3, 2'b00, 1, 0, 0, 2'b00, 1, 1, 1, 3'b000, 0, 1, 0));

    // jal, jr, j
    load(6'b000011, 6'b000000, 0);
    cyc("jal_if", V_IF);
    cyc("jal_id", v(3'd1, 2'b11, 1, 0, 1, 2'b10, 0, 0, 0, 3'b000, 0, 0, 0));
    load(6'b000000, 6'b001000, 0);
    cyc("jr_if", V_IF);
    cyc("jr_id", v(3'd1, 2'b10, 1, 0, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0));
    load(6'b000010, 6'b000000, 0);
    cyc("j_if", V_IF);
    cyc("j_id", v(3'd1, 2'b11, 1, 0, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0));

    // undefined opcode: 2-cycle nop
    load(6'b010101, 6'b000000, 0);
    cyc("undef_if", V_IF);
    cyc("undef_id", v(3'd1, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0));

    // op 000001: bltz when enabled, otherwise a nop
    load(6'b000001, 6'b000000, 0);
`ifdef CTRL_BLTZ_EN
    sign = 1'b1;
    cyc("bltz_if", V_IF);
    cyc("bltz_id", V_ID);
    cyc("bltz_br", v(3'd5, 2'b01, 1, 0, 0, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0));
    sign = 1'b0;
`else
    cyc("op01_if", V_IF);
    cyc("op01_id", v(3'd1, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0));
`endif

    // halt: IF/ID loop with the PC frozen
    load(6'b111111, 6'b000000, 0);
    for (int k = 0; k < 3; k++) begin
      cyc("halt_if", V_IF);
      cyc("halt_id", V_ID);
    end

    // reset releases halt and fetch resumes
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1 check("rst_in_halt", obs, V_RST);
    @(posedge CLK);
    #1 RST_n = 1'b1; op = 6'b000000; funct = 6'b100000;
    cyc("post_halt_if", V_IF);
    cyc("post_halt_id", V_ID);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
